// File: rtl/lib_mem.sv
// Shared types and default sizes for the program-memory responder and its loader.
package lib_mem;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef logic [ADDR_W-1:0] ADDR;
  typedef logic [DATA_W-1:0] WORD;

  typedef enum logic [1:0] {
    RUN,
    LOAD,
    FILL,
    DONE
  } LOAD_STATE;

endpackage

// File: rtl/load_ctrl.sv
// Byte-stream loader control: walks the write pointer through the image, zero-fills
// the tail after an early end, keeps the running checksum and holds the CPU off.
module load_ctrl #(
  parameter int ADDR_W = lib_mem::ADDR_W,
  parameter int DATA_W = lib_mem::DATA_W,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_end,
  output logic              ld_ready,
  output logic              ld_done,
  output logic [DATA_W-1:0] ld_sum,
  output logic              cpu_hold,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);
  import lib_mem::*;

  localparam logic [ADDR_W:0] PTR_LAST = (ADDR_W + 1)'(DEPTH - 1);

  LOAD_STATE         state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0] sum_q, sum_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      ptr_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sum_q   <= sum_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sum_d    = sum_q;
    ld_ready = 1'b0;
    ld_done  = 1'b0;
    cpu_hold = 1'b1;
    wr_en    = 1'b0;
    wr_addr  = ptr_q[ADDR_W-1:0];
    wr_data  = '0;
    case (state_q)
      RUN: begin
        cpu_hold = 1'b0;
        if (ld_start) begin
          state_d = LOAD;
          ptr_d   = '0;
          sum_d   = '0;
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          wr_en   = 1'b1;
          wr_data = ld_data;
          sum_d   = sum_q + ld_data;
          ptr_d   = ptr_q + 1'b1;
        end
        // A byte landing in the last word completes the image; ld_end alongside it adds nothing.
        if (ld_valid && ptr_q == PTR_LAST) begin
          state_d = DONE;
        end else if (ld_end) begin
          state_d = FILL;
        end
      end
      FILL: begin
        wr_en = 1'b1;
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == PTR_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        ld_done = 1'b1;
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign ld_sum = sum_q;

endmodule

// File: rtl/prog_rom_loader.sv
// Program memory on the CPU bus with a zero-latency fetch port; the image can be
// rewritten at run time through the byte loader while the CPU is held.
module prog_rom_loader #(
  parameter int ADDR_W = lib_mem::ADDR_W,
  parameter int DATA_W = lib_mem::DATA_W,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_end,
  output logic              ld_ready,
  output logic              ld_done,
  output logic [DATA_W-1:0] ld_sum,
  output logic              cpu_hold
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  load_ctrl #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_load_ctrl (
    .clk     (clk),
    .reset   (reset),
    .ld_start(ld_start),
    .ld_valid(ld_valid),
    .ld_data (ld_data),
    .ld_end  (ld_end),
    .ld_ready(ld_ready),
    .ld_done (ld_done),
    .ld_sum  (ld_sum),
    .cpu_hold(cpu_hold),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  // Every word clears on reset so an interrupted load never leaves a partial image behind.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        mem_q[gi] <= '0;
      end else if (wr_en && wr_addr == ADDR_W'(gi)) begin
        mem_q[gi] <= wr_data;
      end
    end
  end

  assign mem_data = cpu_hold ? '0 : mem_q[mem_addr];

endmodule

// File: tb/tb_prog_rom_loader.sv
// Directed checks of the program-memory responder and its byte-stream loader.
module tb_prog_rom_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] mem_addr;
  logic [7:0] mem_data;
  logic       ld_start;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_end;
  logic       ld_ready;
  logic       ld_done;
  logic [7:0] ld_sum;
  logic       cpu_hold;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  prog_rom_loader dut (
    .clk     (clk),
    .reset   (reset),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .ld_start(ld_start),
    .ld_valid(ld_valid),
    .ld_data (ld_data),
    .ld_end  (ld_end),
    .ld_ready(ld_ready),
    .ld_done (ld_done),
    .ld_sum  (ld_sum),
    .cpu_hold(cpu_hold)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
    mem_addr = a;
    #1;
    chk(tag, {24'h0, mem_data}, {24'h0, exp});
  endtask

  initial begin
    int n;
    reset = 1'b1; mem_addr = '0; ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_end = 1'b0;
    step(); step();
    chk("rst_cpu_hold", {31'h0, cpu_hold}, 32'h0);
    chk("rst_ld_ready", {31'h0, ld_ready}, 32'h0);
    reset = 1'b0;
    step();
    for (int a = 0; a < 16; a++) rd($sformatf("rst_mem[%0d]", a), 4'(a), 8'h00);
    chk("rst_ld_done", {31'h0, ld_done}, 32'h0);
    chk("rst_ld_sum", {24'h0, ld_sum}, 32'h0);

    // RUN ignores stray bytes
    ld_valid = 1'b1; ld_data = 8'hFF;
    step(); step();
    ld_valid = 1'b0;
    chk("run_ld_ready", {31'h0, ld_ready}, 32'h0);
    chk("run_ld_sum", {24'h0, ld_sum}, 32'h0);
    rd("run_mem[0]", 4'd0, 8'h00);

    // Full 16-byte load
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    chk("l1_cpu_hold", {31'h0, cpu_hold}, 32'h1);
    n = 0;
    for (int i = 0; i < 16; i++) begin
      ld_valid = 1'b1; ld_data = 8'h30 + 8'(i);
      #1;
      if (ld_ready) n++;
      step();
    end
    ld_valid = 1'b0;
    chk("l1_ready_cycles", n, 16);
    chk("l1_ld_done", {31'h0, ld_done}, 32'h1);
    chk("l1_hold_in_done", {31'h0, cpu_hold}, 32'h1);
    chk("l1_ld_sum", {24'h0, ld_sum}, 32'h78);
    step();
    chk("l1_done_cleared", {31'h0, ld_done}, 32'h0);
    chk("l1_hold_low", {31'h0, cpu_hold}, 32'h0);
    chk("l1_sum_stable", {24'h0, ld_sum}, 32'h78);
    rd("l1_mem[0]", 4'd0, 8'h30);
    rd("l1_mem[5]", 4'd5, 8'h35);
    rd("l1_mem[15]", 4'd15, 8'h3F);

    // Short load ending with a coincident byte, then zero fill
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    rd("l2_hold_forced", 4'd2, 8'h00);
    chk("l2_ld_sum_clr", {24'h0, ld_sum}, 32'h0);
    ld_valid = 1'b1; ld_data = 8'hB3; step();
    ld_data = 8'hB6; step();
    ld_valid = 1'b0; ld_start = 1'b1; step();
    ld_start = 1'b0;
    chk("l2_restart_ignored", {31'h0, ld_ready}, 32'h1);
    ld_valid = 1'b1; ld_data = 8'h01; ld_end = 1'b1; step();
    ld_valid = 1'b0; ld_end = 1'b0;
    chk("l2_fill_ready", {31'h0, ld_ready}, 32'h0);
    chk("l2_fill_hold", {31'h0, cpu_hold}, 32'h1);
    n = 0;
    while (!ld_done && n < 40) begin
      step();
      n++;
    end
    chk("l2_fill_cycles", n, 13);
    chk("l2_ld_sum", {24'h0, ld_sum}, 32'h6A);
    step();
    rd("l2_mem[0]", 4'd0, 8'hB3);
    rd("l2_mem[1]", 4'd1, 8'hB6);
    rd("l2_mem[2]", 4'd2, 8'h01);
    rd("l2_mem[3]", 4'd3, 8'h00);
    rd("l2_mem[15]", 4'd15, 8'h00);

    // Reset part way through a load
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      ld_valid = 1'b1; ld_data = 8'h50 + 8'(i);
      step();
    end
    ld_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_mid_hold", {31'h0, cpu_hold}, 32'h0);
    chk("rst_mid_ready", {31'h0, ld_ready}, 32'h0);
    chk("rst_mid_sum", {24'h0, ld_sum}, 32'h0);
    rd("rst_mid_mem[0]", 4'd0, 8'h00);
    rd("rst_mid_mem[2]", 4'd2, 8'h00);
    step();
    reset = 1'b0;
    ld_valid = 1'b1; ld_data = 8'hAA;
    step(); step();
    ld_valid = 1'b0;
    rd("post_rst_mem[0]", 4'd0, 8'h00);
    rd("post_rst_mem[6]", 4'd6, 8'h00);
    chk("post_rst_ready", {31'h0, ld_ready}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/prog_rom_loader.md
Name: prog_rom_loader

Overview:
- Program-memory responder on the memory bus: returns the instruction word at the CPU's fetch address, with a combinational read.
- Adds a byte-stream loader so the board can rewrite the program at run time.
- While a load is in progress it holds the CPU off via cpu_hold; the board ORs this into the CPU reset.
- Sits on the mother board beside the CPU, as the slave end of the CPU's memory bus.

Parameters:
- ADDR_W, 4, memory address width; matches the CPU instruction-pointer width.
- DATA_W, 8, instruction word width.
- DEPTH, 1<<ADDR_W, number of words; must be a power of two.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_addr  in  ADDR_W  fetch address from the memory bus (CPU instruction pointer).
- mem_data  out  DATA_W  instruction word returned to the memory bus.
- ld_start  in  1  single-cycle pulse: begin a load.
- ld_valid  in  1  ld_data holds a byte to write.
- ld_data  in  DATA_W  program byte.
- ld_end  in  1  pulse: source has no more bytes.
- ld_ready  out  1  loader accepts a byte this cycle.
- ld_done  out  1  one-cycle pulse: load complete.
- ld_sum  out  DATA_W  modulo-2^DATA_W sum of accepted bytes; stable from ld_done until the next ld_start.
- cpu_hold  out  1  high while the program image is invalid.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high, ports named clk and reset.
- Reset values: all memory words 0, ptr 0, state RUN, ld_ready 0, ld_done 0, ld_sum 0, cpu_hold 0.
- Read path:
  - mem_data = mem[mem_addr] combinationally, zero latency, because the CPU decodes in the same cycle.
  - While cpu_hold=1, mem_data is forced to 0.
  - A write at cycle N is visible on mem_data from cycle N+1.
- FSM states: RUN, LOAD, FILL, DONE.
- RUN:
  - ld_ready=0, cpu_hold=0.
  - ld_start -> LOAD; ptr<=0, ld_sum<=0, cpu_hold rises next cycle.
  - ld_valid and ld_end are ignored.
- LOAD:
  - ld_ready=1, cpu_hold=1.
  - Accept when ld_valid&ld_ready: mem[ptr]<=ld_data, ld_sum<=ld_sum+ld_data (wraps), ptr<=ptr+1.
  - Accepting with ptr==DEPTH-1 (full) -> DONE; ld_end in the same cycle is redundant.
  - ld_end with no accept, or with an accept at ptr<DEPTH-1 -> FILL.
  - When ld_end and ld_valid coincide, the byte is written first, then FILL starts at ptr+1.
  - ld_start in LOAD is ignored; there is no restart.
- FILL:
  - ld_ready=0, cpu_hold=1.
  - Writes 0 to mem[ptr] each cycle, ptr++; after writing DEPTH-1 -> DONE.
  - ld_end at ptr=0 with no byte accepted zero-fills all DEPTH words over DEPTH cycles.
- DONE:
  - ld_done=1 for exactly this cycle; cpu_hold=1 this cycle; next state RUN.
  - cpu_hold falls on the cycle after DONE, so the CPU restarts fetching from address 0 with the complete image.
- Pointer: ptr is ADDR_W+1 bits internally; only the low ADDR_W bits index memory. It never wraps during a load because both full and FILL terminate at DEPTH-1.
- Reset mid-LOAD or mid-FILL: immediate return to reset values; the partial image is discarded (memory zeroed).
- Bytes presented while ld_ready=0 are dropped; the source must hold ld_valid until it sees ld_ready.

Decomposition:
- Package lib_mem holds:
  - LOAD_STATE enum {RUN, LOAD, FILL, DONE};
  - localparams ADDR_W=4, DATA_W=8;
  - typedefs for ADDR and WORD.
- Sub-module load_ctrl: FSM, pointer, checksum, ld_ready/ld_done/cpu_hold. It emits a write enable, write address and write data.
- The top level holds the register array and the read mux.

Test Plan:
- Reset then mem_addr sweep 0..15 -> mem_data=0x00 at every address; cpu_hold=0, ld_ready=0.
- ld_start; stream 16 bytes 0x30..0x3F with ld_valid held continuously ->
  - ld_ready high 16 cycles; DONE the cycle after the 16th accept; ld_done pulse; ld_sum=0x78.
  - Then mem[5]=0x35, mem[15]=0x3F; cpu_hold low from the next cycle.
- ld_start; bytes 0xB3,0xB6 then ld_end coincident with third byte 0x01 ->
  - mem[0..2]=B3,B6,01; FILL writes mem[3..15]=0x00 over 13 cycles; ld_sum=0x6A.
- While in LOAD, drive mem_addr=2 -> mem_data=0x00 (hold forcing). Assert ld_start again -> ignored, ptr unchanged.
- Assert reset after 7 bytes of a load -> cpu_hold=0, state RUN, all words 0 immediately (async). ld_valid pulses afterwards are not written.
- In RUN, ld_valid=1 with ld_data=0xFF and no ld_start -> memory unchanged, ld_ready=0, ld_sum unchanged.
